perf_counter_uart_reporter: RTL and testbench

- Parametrised successor to the fixed cache-event counter plus UART TX pair.
- Counts NUM_CH independent single-cycle event strobes (L1I/L1D/L2 read, write, miss) in CNT_W-bit saturating counters.
- On a report trigger, snapshots all counters and serialises them as one checksummed 8N1 UART frame.
- Sits between the cache hierarchy event wires and the board UART pin. Adds runtime clear, re-triggerable reporting, saturation and a frame checksum.

---
 rtl/perf_counter_uart_reporter.sv | 165 ++++++++++++++++
 tb/tb_perf_counter_uart_reporter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_uart_reporter.sv
// Per-channel saturating event counters with a snapshot-and-report path that
// serialises all counts as one checksummed 8N1 UART frame.
module perf_counter_uart_reporter #(
    parameter int         NUM_CH       = 8,
    parameter int         CNT_W        = 32,
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] event_i,
    input  logic              clear_i,
    input  logic              cpu_done,
    input  logic              report_i,
    output logic              tx_data,
    output logic              busy,
    output logic              frame_done
);

    localparam int NB        = CNT_W / 8;
    localparam int TOTAL     = 2 + NUM_CH * NB;
    localparam int IDX_W     = $clog2(TOTAL);
    localparam int BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(TOTAL - 1);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, DONE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt  [NUM_CH];
    logic [CNT_W-1:0]   snap [NUM_CH];
    logic [7:0]         chk;
    logic [7:0]         shift;
    logic [7:0]         ld_byte;
    logic [BAUD_W-1:0]  baud;
    logic [2:0]         bit_idx;
    logic [IDX_W-1:0]   byte_idx;
    logic [IDX_W-1:0]   ld_idx;
    logic               cpu_done_q;
    logic               trig;
    logic               bit_end;
    logic               load_en;
    logic               snap_en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign trig    = (cpu_done & ~cpu_done_q) | report_i;
    assign bit_end = (baud == BAUD_MAX);

    // Live counters: clear wins over a same-cycle event
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clear_i)         cnt[i] <= '0;
                else if (event_i[i]) cnt[i] <= sat_inc(cnt[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        load_en    = 1'b0;
        snap_en    = 1'b0;
        ld_idx     = byte_idx + IDX_W'(1);
        tx_data    = 1'b1;
        busy       = (state != IDLE);
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    snap_en  = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                load_en  = 1'b1;
                ld_idx   = '0;
                state_nx = START;
            end
            START: begin
                tx_data = 1'b0;
                if (bit_end) state_nx = DATA;
            end
            DATA: begin
                tx_data = shift[0];
                if (bit_end && bit_idx == 3'd7) state_nx = STOP;
            end
            STOP: begin
                // Next byte loads on the last stop cycle so bytes run back-to-back
                if (bit_end) begin
                    if (byte_idx == LAST_IDX) begin
                        state_nx = DONE;
                    end else begin
                        load_en  = 1'b1;
                        state_nx = START;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ld_byte = HEADER;
        if (ld_idx == LAST_IDX) begin
            ld_byte = chk;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                for (int b = 0; b < NB; b++) begin
                    if (ld_idx == IDX_W'(ch * NB + b + 1))
                        ld_byte = snap[ch][(NB-1-b)*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cpu_done_q <= 1'b0;
            chk        <= '0;
            shift      <= '0;
            baud       <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            for (int i = 0; i < NUM_CH; i++) snap[i] <= '0;
        end else begin
            cpu_done_q <= cpu_done;
            if (snap_en) begin
                for (int i = 0; i < NUM_CH; i++) snap[i] <= cnt[i];
                chk <= '0;
            end
            if (load_en) begin
                shift    <= ld_byte;
                byte_idx <= ld_idx;
                if (ld_idx != LAST_IDX) chk <= chk ^ ld_byte;
            end
            if (state == START || state == DATA || state == STOP)
                baud <= bit_end ? '0 : baud + BAUD_W'(1);
            else
                baud <= '0;
            if (state == DATA) begin
                if (bit_end) begin
                    shift   <= shift >> 1;
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                bit_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_uart_reporter.sv
// Randomised bench for perf_counter_uart_reporter against a cycle-level frame model.
module tb_perf_counter_uart_reporter;

    localparam int NUM_CH    = 2;
    localparam int CNT_W     = 16;
    localparam int CPB       = 4;
    localparam int NB        = CNT_W / 8;
    localparam int TOTAL     = 2 + NUM_CH * NB;
    localparam int FRAME_CYC = TOTAL * 10 * CPB;
    localparam int MAXV      = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NUM_CH-1:0] event_i = '0;
    logic              clear_i = 1'b0;
    logic              cpu_done = 1'b0;
    logic              report_i = 1'b0;
    logic              tx_data;
    logic              busy;
    logic              frame_done;

    int   checks = 0;
    int   errors = 0;
    int   m_cnt [NUM_CH];
    bit   m_cd_q;
    int   m_left;
    bit   m_bits [TOTAL*10];
    logic txq [$];
    int   frame_pulses;

    always #5 clk = ~clk;

    perf_counter_uart_reporter #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CLKS_PER_BIT(CPB), .HEADER(8'hA5)
    ) dut (
        .clk(clk), .rstn(rstn), .event_i(event_i), .clear_i(clear_i),
        .cpu_done(cpu_done), .report_i(report_i), .tx_data(tx_data),
        .busy(busy), .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected serial bit stream from the current model counts
    task automatic build_frame();
        logic [7:0] bytes [TOTAL];
        logic [7:0] x;
        bytes[0] = 8'hA5;
        x = 8'hA5;
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int b = 0; b < NB; b++) begin
                bytes[1 + ch*NB + b] = 8'((m_cnt[ch] >> (8*(NB-1-b))) & 8'hFF);
                x ^= bytes[1 + ch*NB + b];
            end
        bytes[TOTAL-1] = x;
        for (int k = 0; k < TOTAL; k++) begin
            m_bits[k*10] = 1'b0;
            for (int b = 0; b < 8; b++) m_bits[k*10 + 1 + b] = bytes[k][b];
            m_bits[k*10 + 9] = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) m_cnt[ch] = 0;
        m_cd_q = 1'b0;
        m_left = 0;
    endtask

    task automatic cycle();
        bit trig;
        int pos;
        logic exp_tx;
        @(posedge clk);
        trig = ((cpu_done === 1'b1) && !m_cd_q) || (report_i === 1'b1);
        if (m_left > 0) m_left--;
        else if (trig) begin
            build_frame();
            m_left = FRAME_CYC + 2;
        end
        m_cd_q = (cpu_done === 1'b1);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (clear_i) m_cnt[ch] = 0;
            else if (event_i[ch]) m_cnt[ch] = (m_cnt[ch] < MAXV) ? m_cnt[ch] + 1 : MAXV;
        end
        @(negedge clk);
        pos = FRAME_CYC + 1 - m_left;
        exp_tx = (m_left > 0 && pos >= 0 && pos < FRAME_CYC) ? m_bits[pos / CPB] : 1'b1;
        check("tx_data", tx_data, exp_tx);
        check("busy", busy, (m_left > 0));
        check("frame_done", frame_done, (m_left == 1));
        txq.push_back(tx_data);
    endtask

    task automatic run_frame(input bit rnd, input bit retrig);
        int n = 0;
        frame_pulses = 0;
        while (m_left > 0 && n < FRAME_CYC + 20) begin
            event_i = rnd ? NUM_CH'($urandom) : '0;
            if (retrig) begin
                if (n == 50) report_i = 1'b1;
                if (n == 51) report_i = 1'b0;
                if (n == 60 || n == 80) cpu_done = ~cpu_done;
            end
            cycle();
            if (frame_done === 1'b1) frame_pulses++;
            n++;
        end
        event_i  = '0;
        report_i = 1'b0;
    endtask

    task automatic get_byte(input int n, output logic [7:0] v);
        int s = -1;
        v = 'x;
        for (int i = 0; i < txq.size(); i++)
            if (txq[i] === 1'b0) begin s = i; break; end
        if (s >= 0 && s + n*40 + 38 < txq.size())
            for (int b = 0; b < 8; b++) v[b] = txq[s + n*40 + CPB*(1+b) + 2];
    endtask

    task automatic report_frame(input bit rnd, input bit retrig);
        txq.delete();
        report_i = 1'b1;
        cycle();
        report_i = 1'b0;
        run_frame(rnd, retrig);
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] exp6 [6];
        int s;

        model_reset();
        #12;
        check("reset_tx", tx_data, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", frame_done, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        // Basic frame
        for (int i = 0; i < 5; i++) begin
            event_i = {1'(i < 5), 1'(i < 3)};
            cycle();
        end
        event_i = '0;
        txq.delete();
        cpu_done = 1'b1;
        cycle();
        run_frame(1'b0, 1'b0);
        check("basic_pulses", frame_pulses, 1);
        exp6 = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h05, 8'hA3};
        for (int i = 0; i < 6; i++) begin
            get_byte(i, got);
            check($sformatf("basic_b%0d", i), got, exp6[i]);
        end
        s = -1;
        for (int i = 0; i < txq.size(); i++)
            if (txq[i] === 1'b0) begin s = i; break; end
        check("start_found", (s > 0), 1);
        if (s > 0) begin
            check("start_pre_idle", txq[s-1], 1'b1);
            for (int c = 0; c < 4; c++) check("start_low", txq[s+c], 1'b0);
            check("start_len", txq[s+4], 1'b1);
            check("stop_bit", txq[s+38], 1'b1);
        end
        cycle();
        check("basic_idle_busy", busy, 1'b0);

        // Clear beats event; event on trigger cycle is not in the snapshot
        clear_i = 1'b1; event_i = 2'b01; cycle();
        clear_i = 1'b0; event_i = 2'b10; cycle();
        cycle();
        txq.delete();
        event_i = 2'b10; report_i = 1'b1; cycle();
        report_i = 1'b0; event_i = '0;
        run_frame(1'b0, 1'b0);
        get_byte(2, got); check("clr_ch0_lo", got, 8'h00);
        get_byte(4, got); check("trig_ch1_lo", got, 8'h02);
        cycle();

        // Re-trigger mid-frame is ignored; later report shows live count 3
        report_frame(1'b0, 1'b1);
        get_byte(4, got); check("after_ch1_lo", got, 8'h03);
        for (int i = 0; i < 300; i++) cycle();
        report_frame(1'b1, 1'b0);

        // Randomised traffic
        for (int k = 0; k < 4; k++) begin
            int len = $urandom_range(30, 80);
            for (int i = 0; i < len; i++) begin
                event_i = NUM_CH'($urandom);
                clear_i = ($urandom_range(0, 19) == 0);
                cycle();
            end
            clear_i = 1'b0;
            if (k[0]) begin
                cpu_done = 1'b0; cycle();
                txq.delete();
                cpu_done = 1'b1; cycle();
                run_frame(1'b1, 1'b0);
            end else begin
                report_frame(1'b1, k == 2);
            end
        end

        // Saturation
        event_i = 2'b01;
        for (int i = 0; i < 70000; i++) cycle();
        report_frame(1'b0, 1'b0);
        get_byte(1, got); check("sat_hi", got, 8'hFF);
        get_byte(2, got); check("sat_lo", got, 8'hFF);
        event_i = 2'b01;
        for (int i = 0; i < 10; i++) cycle();
        event_i = '0;
        report_frame(1'b0, 1'b0);
        get_byte(1, got); check("sat2_hi", got, 8'hFF);
        get_byte(2, got); check("sat2_lo", got, 8'hFF);

        // Reset mid-frame during data bits of byte 3
        report_i = 1'b1; cycle(); report_i = 1'b0;
        for (int i = 0; i < 1 + 3*40 + 14; i++) cycle();
        check("pre_rst_busy", busy, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("rst_tx", tx_data, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        model_reset();
        cpu_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cycle();
        report_frame(1'b0, 1'b0);
        exp6 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
        for (int i = 0; i < 6; i++) begin
            get_byte(i, got);
            check($sformatf("post_rst_b%0d", i), got, exp6[i]);
        end
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
